// File: rtl/rv32i_bus_arbiter.sv
// Round-robin Wishbone bus arbiter for the RV32I core complex.
// Masters (0 = icache, 1 = data unit, 2 = debug/DMA) request ownership with
// req_i, the winner gets a registered one-hot grant_o and its bus signals are
// muxed onto the single slave port. A stalled strobe is aborted after
// TIMEOUT_CYCLES unanswered cycles.
// Ports:
//   clk_i, reset_ni            clock, async active-low reset
//   req_i / grant_o            per-master ownership request / one-hot grant
//   m_adr_i..m_stb_i           packed per-master Wishbone request signals
//   m_dat_o, m_ack_o, m_err_o  read data (broadcast), per-master ack / error
//   s_adr_o..s_cyc_o           slave-side Wishbone request signals
//   s_dat_i, s_ack_i, s_err_i  slave-side responses
//   timeout_o                  one-cycle pulse when a strobe is aborted
module rv32i_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic [NUM_MASTERS-1:0]          req_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]     m_dat_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*4-1:0]        m_sel_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  output logic [XLEN-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [XLEN-3:0]                 s_adr_o,
  output logic [XLEN-1:0]                 s_dat_o,
  output logic                            s_we_o,
  output logic [3:0]                      s_sel_o,
  output logic                            s_stb_o,
  output logic                            s_cyc_o,
  input  logic [XLEN-1:0]                 s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  output logic                            timeout_o
);

  localparam int unsigned AW = XLEN - 2;
  localparam int unsigned OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t                 state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   tmo_d;
  logic                   armed_q;
  logic [OW-1:0]          pick;
  logic                   pick_vld;
  logic                   own_req;

  assign m_dat_o = s_dat_i;

  // Round-robin pick: first requester at or after last_owner+1 (mod N).
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        if (!pick_vld && req_i[k] && (((32'(last_q) + i) % NUM_MASTERS) == k)) begin
          pick_vld = 1'b1;
          pick     = OW'(k);
        end
      end
    end
  end

  // Owner mux onto the slave port and response demux back to the owner.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    own_req = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (32'(owner_q) == k) begin
        own_req = req_i[k];
        if (state_q == GRANT) begin
          s_adr_o    = m_adr_i[k*AW +: AW];
          s_dat_o    = m_dat_i[k*XLEN +: XLEN];
          s_we_o     = m_we_i[k];
          s_sel_o    = m_sel_i[k*4 +: 4];
          s_stb_o    = m_stb_i[k];
          m_ack_o[k] = s_ack_i;
          m_err_o[k] = s_err_i;
        end else if (state_q == ABORT) begin
          // Error to the owner only during the registered timeout pulse.
          m_err_o[k] = timeout_o;
        end
      end
    end
    s_cyc_o = (state_q == GRANT);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_o;
    cnt_d   = '0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        // armed_q holds off the first grant until the second edge after reset.
        if (armed_q && pick_vld) begin
          state_d = GRANT;
          owner_d = pick;
          last_d  = pick;
          grant_d = NUM_MASTERS'(1) << pick;
        end
      end
      GRANT: begin
        if (s_stb_o && !s_ack_i && !s_err_i && (cnt_q == CNT_LAST)) begin
          // Last unanswered strobe cycle: pulse appears in the first ABORT cycle.
          state_d = ABORT;
          cnt_d   = CNT_MAX;
          tmo_d   = 1'b1;
        end else if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (s_stb_o && !s_ack_i && !s_err_i && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ABORT: begin
        if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= OW'(NUM_MASTERS - 1);
      grant_o   <= '0;
      cnt_q     <= '0;
      timeout_o <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_o   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_o <= tmo_d;
      armed_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_bus_arbiter.sv
// Self-checking bench for rv32i_bus_arbiter: cycle-by-cycle vector table for
// round-robin grant/ack/err behaviour plus directed timeout, hold and reset
// sequences.
module tb_rv32i_bus_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned XL = 32;
  localparam int unsigned AW = XL - 2;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic [N-1:0]    req_i;
  logic [N-1:0]    grant_o;
  logic [N*AW-1:0] m_adr_i;
  logic [N*XL-1:0] m_dat_i;
  logic [N-1:0]    m_we_i;
  logic [N*4-1:0]  m_sel_i;
  logic [N-1:0]    m_stb_i;
  logic [XL-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;
  logic [AW-1:0]   s_adr_o;
  logic [XL-1:0]   s_dat_o;
  logic            s_we_o;
  logic [3:0]      s_sel_o;
  logic            s_stb_o;
  logic            s_cyc_o;
  logic [XL-1:0]   s_dat_i;
  logic            s_ack_i;
  logic            s_err_i;
  logic            timeout_o;

  rv32i_bus_arbiter #(.NUM_MASTERS(N), .XLEN(XL), .TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_i(req_i), .grant_o(grant_o),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] req;
    logic [2:0] stb;
    logic       ack;
    logic       err;
    logic [2:0] grant;
    logic       cyc;
    logic       sstb;
    logic [2:0] mack;
    logic [2:0] merr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  logic [AW-1:0] adr_tab [N];
  logic [XL-1:0] dat_tab [N];
  logic [3:0]    sel_tab [N];
  logic [N-1:0]  we_bits;

  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] stb,
                              input logic ack, input logic err,
                              input logic [2:0] grant, input logic cyc,
                              input logic sstb, input logic [2:0] mack,
                              input logic [2:0] merr);
    vec_t v;
    v.req = req; v.stb = stb; v.ack = ack; v.err = err;
    v.grant = grant; v.cyc = cyc; v.sstb = sstb; v.mack = mack; v.merr = merr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] stb,
                       input logic ack, input logic err);
    req_i   = req;
    m_stb_i = stb;
    s_ack_i = ack;
    s_err_i = err;
  endtask

  // Expected slave-side request signals given the expected one-hot owner.
  task automatic check_mux(input string tag, input logic cyc, input logic [2:0] grant);
    logic [AW-1:0] ea;
    logic [XL-1:0] ed;
    logic [3:0]    es;
    logic          ew;
    ea = '0; ed = '0; es = '0; ew = 1'b0;
    if (cyc) begin
      for (int k = 0; k < N; k++) begin
        if (grant[k]) begin
          ea = adr_tab[k]; ed = dat_tab[k]; es = sel_tab[k]; ew = we_bits[k];
        end
      end
    end
    check({tag, ".s_adr"}, 64'(s_adr_o), 64'(ea));
    check({tag, ".s_dat"}, 64'(s_dat_o), 64'(ed));
    check({tag, ".s_sel"}, 64'(s_sel_o), 64'(es));
    check({tag, ".s_we"},  64'(s_we_o),  64'(ew));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    adr_tab[0] = 30'h0000_0040;
    adr_tab[1] = 30'h0000_0100;
    adr_tab[2] = 30'h3FFF_FFFF;
    dat_tab[0] = 32'hA000_0000;
    dat_tab[1] = 32'hB111_1111;
    dat_tab[2] = 32'hC222_2222;
    sel_tab[0] = 4'hF;
    sel_tab[1] = 4'h3;
    sel_tab[2] = 4'h8;
    we_bits    = 3'b010;
    for (int k = 0; k < N; k++) begin
      m_adr_i[k*AW +: AW] = adr_tab[k];
      m_dat_i[k*XL +: XL] = dat_tab[k];
      m_sel_i[k*4 +: 4]   = sel_tab[k];
    end
    m_we_i  = we_bits;
    s_dat_i = 32'h0;

    //                req     stb     ack   err  | grant  cyc   sstb  mack    merr
    vecs[0]  = mk(3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    vecs[1]  = mk(3'b111, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, 3'b000);
    vecs[2]  = mk(3'b111, 3'b001, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 3'b001, 3'b000);
    vecs[3]  = mk(3'b110, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000);
    vecs[4]  = mk(3'b110, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    vecs[5]  = mk(3'b110, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 3'b000);
    vecs[6]  = mk(3'b110, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 3'b000);
    vecs[7]  = mk(3'b110, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 3'b000);
    vecs[8]  = mk(3'b111, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 3'b010, 3'b000);
    vecs[9]  = mk(3'b111, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000);
    vecs[10] = mk(3'b101, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 3'b010, 3'b000);
    vecs[11] = mk(3'b101, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    vecs[12] = mk(3'b101, 3'b100, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 3'b000, 3'b100);
    vecs[13] = mk(3'b101, 3'b100, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 3'b100, 3'b000);
    vecs[14] = mk(3'b001, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 3'b000, 3'b000);
    vecs[15] = mk(3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    vecs[16] = mk(3'b001, 3'b001, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 3'b001, 3'b000);
    vecs[17] = mk(3'b000, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000);
    vecs[18] = mk(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    vecs[19] = mk(3'b000, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    vecs[20] = mk(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);

    // Reset with all masters already requesting.
    reset_ni = 1'b0;
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    @(negedge clk_i);
    check("rst.grant",   64'(grant_o),   64'(0));
    check("rst.cyc",     64'(s_cyc_o),   64'(0));
    check("rst.timeout", 64'(timeout_o), 64'(0));
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Table: grant order 0,1,2,0, ack/err routing, no preemption.
    for (int i = 0; i < NV; i++) begin
      string tag;
      logic [XL-1:0] rd;
      tag = $sformatf("vec%0d", i);
      tick();
      drive(vecs[i].req, vecs[i].stb, vecs[i].ack, vecs[i].err);
      rd = XL'($urandom);
      s_dat_i = rd;
      @(negedge clk_i);
      check({tag, ".grant"},   64'(grant_o),   64'(vecs[i].grant));
      check({tag, ".cyc"},     64'(s_cyc_o),   64'(vecs[i].cyc));
      check({tag, ".stb"},     64'(s_stb_o),   64'(vecs[i].sstb));
      check({tag, ".m_ack"},   64'(m_ack_o),   64'(vecs[i].mack));
      check({tag, ".m_err"},   64'(m_err_o),   64'(vecs[i].merr));
      check({tag, ".timeout"}, 64'(timeout_o), 64'(0));
      check({tag, ".m_dat"},   64'(m_dat_o),   64'(rd));
      check_mux(tag, vecs[i].cyc, vecs[i].grant);
    end

    // Timeout: master 0 strobes and the slave never answers.
    tick();
    drive(3'b001, 3'b000, 1'b0, 1'b0);
    @(negedge clk_i);
    check("to.pre_grant", 64'(grant_o), 64'(0));
    tick();
    m_stb_i = 3'b001;
    for (int n = 1; n <= 255; n++) begin
      @(negedge clk_i);
      check($sformatf("to.stb%0d", n),     64'(s_stb_o),   64'(1));
      check($sformatf("to.tmo%0d", n),     64'(timeout_o), 64'(0));
      check($sformatf("to.err%0d", n),     64'(m_err_o),   64'(0));
      tick();
    end
    s_ack_i = 1'b1;
    #1;
    check("to.pulse",      64'(timeout_o), 64'(1));
    check("to.err_pulse",  64'(m_err_o),   64'(3'b001));
    check("to.stb_off",    64'(s_stb_o),   64'(0));
    check("to.cyc_off",    64'(s_cyc_o),   64'(0));
    check("to.ack_ignored", 64'(m_ack_o),  64'(0));
    check("to.grant_held", 64'(grant_o),   64'(3'b001));
    tick();
    @(negedge clk_i);
    check("to.pulse_end",  64'(timeout_o), 64'(0));
    check("to.err_end",    64'(m_err_o),   64'(0));
    check("to.grant_held2", 64'(grant_o),  64'(3'b001));
    tick();
    drive(3'b000, 3'b000, 1'b0, 1'b0);
    @(negedge clk_i);
    check("to.grant_held3", 64'(grant_o), 64'(3'b001));
    tick();
    @(negedge clk_i);
    check("to.released", 64'(grant_o), 64'(0));

    // Master 2 holds the bus for 20 cycles while master 0 waits.
    tick();
    drive(3'b100, 3'b000, 1'b0, 1'b0);
    @(negedge clk_i);
    check("hold.pre", 64'(grant_o), 64'(0));
    for (int c = 0; c < 20; c++) begin
      tick();
      req_i = 3'b101;
      @(negedge clk_i);
      check($sformatf("hold.c%0d", c), 64'(grant_o), 64'(3'b100));
    end
    tick();
    req_i = 3'b001;
    @(negedge clk_i);
    check("hold.drop", 64'(grant_o), 64'(3'b100));
    tick();
    @(negedge clk_i);
    check("hold.idle", 64'(grant_o), 64'(0));
    tick();
    @(negedge clk_i);
    check("hold.next", 64'(grant_o), 64'(3'b001));
    tick();
    req_i = 3'b000;
    tick();
    @(negedge clk_i);
    check("hold.done", 64'(grant_o), 64'(0));

    // Reset mid-strobe while master 1 owns the bus.
    tick();
    drive(3'b010, 3'b000, 1'b0, 1'b0);
    @(negedge clk_i);
    check("mr.pre", 64'(grant_o), 64'(0));
    tick();
    m_stb_i = 3'b010;
    @(negedge clk_i);
    check("mr.grant", 64'(grant_o), 64'(3'b010));
    check("mr.stb",   64'(s_stb_o), 64'(1));
    tick();
    #2;
    reset_ni = 1'b0;
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    #1;
    check("mr.grant0", 64'(grant_o),   64'(0));
    check("mr.cyc0",   64'(s_cyc_o),   64'(0));
    check("mr.stb0",   64'(s_stb_o),   64'(0));
    check("mr.ack0",   64'(m_ack_o),   64'(0));
    check("mr.err0",   64'(m_err_o),   64'(0));
    check("mr.tmo0",   64'(timeout_o), 64'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
    @(negedge clk_i);
    check("mr.edge1", 64'(grant_o), 64'(0));
    tick();
    @(negedge clk_i);
    check("mr.edge2_m0", 64'(grant_o), 64'(3'b001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
